// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-requester data-memory arbiter: memory command codes,
// FSM state encoding and the command-select helper.
package mem_arbiter_pkg;

  typedef logic [7:0] data_t;

  localparam data_t CMD_IDLE  = 8'h00;
  localparam data_t CMD_READ  = 8'h01;
  localparam data_t CMD_WRITE = 8'h02;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StDone  = 2'd3
  } state_e;

  function automatic data_t cmd_for(input logic we);
    return we ? CMD_WRITE : CMD_READ;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side handshake bundle: per-requester request/address/data in,
// grant, completion pulse, read data and busy out.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic [1:0] req;
  logic [1:0] we;
  data_t      addr0;
  data_t      addr1;
  data_t      wdata0;
  data_t      wdata1;
  logic [1:0] gnt;
  logic [1:0] done;
  data_t      rdata;
  logic       busy;

  modport master (
    output req, we, addr0, addr1, wdata0, wdata1,
    input  gnt, done, rdata, busy
  );

  modport slave (
    input  req, we, addr0, addr1, wdata0, wdata1,
    output gnt, done, rdata, busy
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the requester
// that was not granted last (last = 1 means requester 1 had the previous grant).
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] winner
);

  always_comb begin
    case (req)
      2'b01:   winner = 2'b01;
      2'b10:   winner = 2'b10;
      2'b11:   winner = last ? 2'b01 : 2'b10;
      default: winner = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two requesters onto a single data memory: one transaction at a time,
// registered command/address, tri-stated write data, read data sampled after RD_LAT.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave req_bus,
  output data_t        cmd_memory,
  output data_t        addr_memory,
  inout  wire [7:0]    data_memory
);

  localparam logic [2:0] WaitLoad = 3'(RD_LAT - 1);

  state_e     state_q;
  logic [1:0] gnt_q;
  logic [1:0] done_q;
  logic       last_q;
  logic       we_q;
  logic       busy_q;
  logic       drive_q;
  logic [2:0] wait_q;
  data_t      cmd_q;
  data_t      addr_q;
  data_t      wdata_q;
  data_t      rdata_q;

  logic [1:0] winner;
  logic       sel_we;
  data_t      sel_addr;
  data_t      sel_wdata;

  rr_arb2 u_rr_arb2 (
    .req    (req_bus.req),
    .last   (last_q),
    .winner (winner)
  );

  always_comb begin
    sel_we    = |(req_bus.we & winner);
    sel_addr  = winner[1] ? req_bus.addr1 : req_bus.addr0;
    sel_wdata = winner[1] ? req_bus.wdata1 : req_bus.wdata0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      drive_q <= 1'b0;
      wait_q  <= 3'd0;
      cmd_q   <= CMD_IDLE;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (winner != 2'b00) begin
            state_q <= StIssue;
            gnt_q   <= winner;
            last_q  <= winner[1];
            busy_q  <= 1'b1;
            we_q    <= sel_we;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            cmd_q   <= cmd_for(sel_we);
            drive_q <= sel_we;
          end
        end
        StIssue: begin
          cmd_q   <= CMD_IDLE;
          drive_q <= 1'b0;
          wait_q  <= WaitLoad;
          if (we_q) begin
            state_q <= StDone;
            done_q  <= gnt_q;
          end else begin
            state_q <= StWait;
          end
        end
        StWait: begin
          // Memory data is valid in the last wait cycle.
          if (wait_q == 3'd0) begin
            rdata_q <= data_memory;
            done_q  <= gnt_q;
            state_q <= StDone;
          end else begin
            wait_q <= wait_q - 3'd1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 2'b00;
          gnt_q   <= 2'b00;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_bus.gnt   = gnt_q;
  assign req_bus.done  = done_q;
  assign req_bus.rdata = rdata_q;
  assign req_bus.busy  = busy_q;
  assign cmd_memory    = cmd_q;
  assign addr_memory   = addr_q;
  assign data_memory   = drive_q ? wdata_q : 8'hzz;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: RD_LAT=1 and RD_LAT=3 instances behind one stimulus source,
// a shared memory model, a transaction-level reference model, vectors and random traffic.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel = 1'b0;
  logic [1:0] req = 2'b00;
  logic [1:0] we = 2'b00;
  logic [7:0] addr0 = 8'h00;
  logic [7:0] addr1 = 8'h00;
  logic [7:0] wdata0 = 8'h00;
  logic [7:0] wdata1 = 8'h00;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  mem_arbiter_if if1 ();
  mem_arbiter_if if3 ();
  wire  [7:0] dbus1;
  wire  [7:0] dbus3;
  logic [7:0] cmd1, cmd3, am1, am3;

  assign if1.req    = sel ? 2'b00 : req;
  assign if3.req    = sel ? req : 2'b00;
  assign if1.we     = we;
  assign if3.we     = we;
  assign if1.addr0  = addr0;
  assign if3.addr0  = addr0;
  assign if1.addr1  = addr1;
  assign if3.addr1  = addr1;
  assign if1.wdata0 = wdata0;
  assign if3.wdata0 = wdata0;
  assign if1.wdata1 = wdata1;
  assign if3.wdata1 = wdata1;

  mem_arbiter #(.RD_LAT(1)) u_dut1 (
    .clk         (clk),
    .rst         (rst),
    .req_bus     (if1),
    .cmd_memory  (cmd1),
    .addr_memory (am1),
    .data_memory (dbus1)
  );

  mem_arbiter #(.RD_LAT(3)) u_dut3 (
    .clk         (clk),
    .rst         (rst),
    .req_bus     (if3),
    .cmd_memory  (cmd3),
    .addr_memory (am3),
    .data_memory (dbus3)
  );

  // View of whichever instance is selected
  logic [1:0] gnt_m, done_m;
  logic [7:0] rdata_m, cmd_m, am_m, bus_m;
  logic       busy_m;

  always_comb begin
    gnt_m   = sel ? if3.gnt : if1.gnt;
    done_m  = sel ? if3.done : if1.done;
    rdata_m = sel ? if3.rdata : if1.rdata;
    busy_m  = sel ? if3.busy : if1.busy;
    cmd_m   = sel ? cmd3 : cmd1;
    am_m    = sel ? am3 : am1;
    bus_m   = sel ? dbus3 : dbus1;
  end

  function automatic logic [7:0] init_val(input int i);
    if (i == 'h20) return 8'h3C;
    if (i == 'h05) return 8'h7F;
    return 8'(i) ^ 8'hC3;
  endfunction

  // Memory: reloaded on every reset, captures writes from the bus, drives read data
  // onto the bus from the read command until the completion pulse.
  logic [7:0] mem [256];
  logic       rd_act;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_act <= 1'b0;
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else begin
      if (cmd_m == CMD_WRITE) mem[am_m] <= bus_m;
      if (cmd_m == CMD_READ) rd_act <= 1'b1;
      else if (|done_m) rd_act <= 1'b0;
    end
  end

  assign dbus1 = (!sel && rd_act) ? mem[am1] : 8'hzz;
  assign dbus3 = (sel && rd_act) ? mem[am3] : 8'hzz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one transaction at a time, timeline from the grant cycle g:
  // command at g+1, done at g+2 (+RD_LAT for reads), idle the cycle after done.
  initial begin : monitor
    int         c, m_g, m_done_c, m_owner, m_last, win, lat;
    logic       m_valid, m_active, m_sel, m_we, exp_busy;
    logic [7:0] m_addr, m_wdata, m_rd, exp_rdata, exp_cmd;
    logic [1:0] exp_gnt, exp_done;
    logic [7:0] mmem [256];
    c = 0; m_g = 0; m_done_c = 0; m_owner = 0; m_last = 1; win = 0;
    m_valid = 1'b0; m_active = 1'b0; m_sel = 1'b0; m_we = 1'b0;
    m_addr = 8'h00; m_wdata = 8'h00; m_rd = 8'h00; exp_rdata = 8'h00;
    forever begin
      @(negedge clk);
      c++;
      if (sel != m_sel) begin
        m_valid = 1'b0;
        m_sel   = sel;
      end
      lat = sel ? 3 : 1;
      if (m_valid) begin
        exp_gnt  = 2'b00;
        exp_done = 2'b00;
        exp_busy = 1'b0;
        exp_cmd  = CMD_IDLE;
        if (m_active) begin
          exp_gnt  = 2'(1 << m_owner);
          exp_busy = 1'b1;
          if (c == m_g + 1) exp_cmd = m_we ? CMD_WRITE : CMD_READ;
          if (c == m_done_c) begin
            exp_done = exp_gnt;
            if (!m_we) exp_rdata = m_rd;
          end
          chk("addr_memory", 32'(am_m), 32'(m_addr));
          if (c == m_g + 1 && m_we) chk("write bus data", 32'(bus_m), 32'(m_wdata));
        end
        chk("gnt", 32'(gnt_m), 32'(exp_gnt));
        chk("done", 32'(done_m), 32'(exp_done));
        chk("busy", 32'(busy_m), 32'(exp_busy));
        chk("cmd_memory", 32'(cmd_m), 32'(exp_cmd));
        chk("rdata", 32'(rdata_m), 32'(exp_rdata));
      end
      if (rst) begin
        m_valid   = 1'b1;
        m_active  = 1'b0;
        m_last    = 1;
        exp_rdata = 8'h00;
        for (int i = 0; i < 256; i++) mmem[i] = init_val(i);
      end else if (m_valid) begin
        if (m_active && c == m_done_c) begin
          m_active = 1'b0;
        end else if (!m_active && req != 2'b00) begin
          if (req == 2'b11) win = 1 - m_last;
          else win = req[1] ? 1 : 0;
          m_owner  = win;
          m_last   = win;
          m_g      = c;
          m_active = 1'b1;
          m_we     = we[win];
          m_addr   = (win == 1) ? addr1 : addr0;
          m_wdata  = (win == 1) ? wdata1 : wdata0;
          m_done_c = c + 2 + (m_we ? 0 : lat);
          if (m_we) mmem[m_addr] = m_wdata;
          else m_rd = mmem[m_addr];
        end
      end
    end
  end

  typedef struct {
    bit         do_rst;
    bit         sel;
    logic [1:0] req;
    logic [1:0] we;
    logic [7:0] a0;
    logic [7:0] a1;
    logic [7:0] w0;
    logic [7:0] w1;
    logic [1:0] gnt;
    int         dly;
    logic [7:0] rdata;
  } vec_t;

  vec_t vecs [12];

  task automatic do_reset(input logic s);
    @(posedge clk); #1;
    rst = 1'b1;
    sel = s;
    req = 2'b00;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Applies one request set, waits for the completion pulse, then leaves one idle
  // cycle with every request low.
  task automatic run_vec(input vec_t v);
    int         got_k;
    logic [1:0] got_gnt;
    logic [7:0] got_rdata;
    if (v.do_rst) do_reset(v.sel);
    req = v.req; we = v.we;
    addr0 = v.a0; addr1 = v.a1; wdata0 = v.w0; wdata1 = v.w1;
    got_k = -1; got_gnt = 2'b00; got_rdata = 8'h00;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (|done_m) begin
        got_k     = k;
        got_gnt   = gnt_m;
        got_rdata = rdata_m;
        break;
      end
    end
    chk("vector done latency", 32'(got_k), 32'(v.dly));
    chk("vector grant", 32'(got_gnt), 32'(v.gnt));
    chk("vector rdata", 32'(got_rdata), 32'(v.rdata));
    @(posedge clk); #1;
    req = 2'b00;
    @(posedge clk); #1;
  endtask

  task automatic random_phase(input logic s, input int ncyc);
    logic [1:0] pend;
    logic [1:0] dn;
    do_reset(s);
    pend = 2'b00;
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      dn = done_m;
      @(posedge clk); #1;
      for (int r = 0; r < 2; r++) begin
        if (pend[r] && dn[r]) begin
          pend[r] = 1'b0;
          req[r]  = 1'b0;
        end else if (!pend[r] && $urandom_range(0, 2) == 0) begin
          pend[r] = 1'b1;
          req[r]  = 1'b1;
          we[r]   = 1'($urandom_range(0, 1));
          if (r == 0) begin
            addr0  = 8'($urandom_range(0, 7));
            wdata0 = 8'($urandom);
          end else begin
            addr1  = 8'($urandom_range(0, 7));
            wdata1 = 8'($urandom);
          end
        end
      end
    end
    req = 2'b00;
    repeat (8) @(posedge clk);
    #1;
  endtask

  initial begin : stimulus
    logic [1:0] seen;
    vecs[0]  = '{1'b1, 1'b0, 2'b01, 2'b01, 8'h10, 8'h00, 8'hA5, 8'h00, 2'b01, 2, 8'h00};
    vecs[1]  = '{1'b0, 1'b0, 2'b10, 2'b00, 8'h00, 8'h20, 8'h00, 8'h00, 2'b10, 3, 8'h3C};
    vecs[2]  = '{1'b0, 1'b0, 2'b11, 2'b00, 8'h05, 8'h20, 8'h00, 8'h00, 2'b01, 3, 8'h7F};
    vecs[3]  = '{1'b0, 1'b0, 2'b11, 2'b11, 8'h30, 8'h31, 8'h11, 8'h22, 2'b10, 2, 8'h7F};
    vecs[4]  = '{1'b0, 1'b0, 2'b10, 2'b00, 8'h00, 8'h31, 8'h00, 8'h00, 2'b10, 3, 8'h22};
    vecs[5]  = '{1'b0, 1'b0, 2'b11, 2'b00, 8'h10, 8'h31, 8'h00, 8'h00, 2'b01, 3, 8'hA5};
    vecs[6]  = '{1'b0, 1'b0, 2'b01, 2'b00, 8'h30, 8'h00, 8'h00, 8'h00, 2'b01, 3, 8'hF3};
    vecs[7]  = '{1'b0, 1'b0, 2'b11, 2'b10, 8'h41, 8'h40, 8'h00, 8'h99, 2'b10, 2, 8'hF3};
    vecs[8]  = '{1'b1, 1'b1, 2'b01, 2'b00, 8'h05, 8'h00, 8'h00, 8'h00, 2'b01, 5, 8'h7F};
    vecs[9]  = '{1'b0, 1'b1, 2'b11, 2'b00, 8'h40, 8'h20, 8'h00, 8'h00, 2'b10, 5, 8'h3C};
    vecs[10] = '{1'b0, 1'b1, 2'b01, 2'b01, 8'h40, 8'h00, 8'h5E, 8'h00, 2'b01, 2, 8'h3C};
    vecs[11] = '{1'b0, 1'b1, 2'b11, 2'b00, 8'h40, 8'h40, 8'h00, 8'h00, 2'b10, 5, 8'h5E};

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Both requesters held high: grants must alternate starting with requester 0
    do_reset(1'b0);
    req = 2'b11; we = 2'b01;
    addr0 = 8'h50; addr1 = 8'h50; wdata0 = 8'h6B; wdata1 = 8'h00;
    for (int t = 0; t < 8; t++) begin
      seen = 2'b00;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (|done_m) begin
          seen = done_m;
          break;
        end
      end
      chk("round-robin order", 32'(seen), (t % 2 == 0) ? 32'd1 : 32'd2);
    end
    @(posedge clk); #1;
    req = 2'b00;
    @(posedge clk); #1;

    // Reset during a read wait aborts it; pointer goes back to favouring requester 0
    run_vec(vecs[8]);
    req = 2'b01; we = 2'b00; addr0 = 8'h20;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    req = 2'b11; addr1 = 8'h05;
    @(negedge clk);
    chk("abort busy", 32'(busy_m), 32'd0);
    chk("abort gnt", 32'(gnt_m), 32'd0);
    chk("abort done", 32'(done_m), 32'd0);
    chk("abort cmd", 32'(cmd_m), 32'(CMD_IDLE));
    chk("abort rdata", 32'(rdata_m), 32'd0);
    seen = 2'b00;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (|done_m) begin
        seen = done_m;
        break;
      end
    end
    chk("post-reset grant", 32'(seen), 32'd1);
    @(posedge clk); #1;
    req = 2'b00;
    @(posedge clk); #1;

    random_phase(1'b0, 250);
    random_phase(1'b1, 250);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion before %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter RD_LAT, default 1, meaning: cycles from read command issue to data_memory sampling (legal 1..4).
REQ-002 clk  input  1  single system clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req  input  2  per-requester transaction request (bit 0 = control unit, bit 1 = loader/DMA).
REQ-005 we  input  2  per-requester write enable (1 = write, 0 = read), valid while req high.
REQ-006 addr0, addr1  input  8 each  per-requester data-memory address.
REQ-007 wdata0, wdata1  input  8 each  per-requester write data.
REQ-008 gnt  output  2  one-hot grant, identifies the requester owning the current transaction.
REQ-009 done  output  2  one-cycle completion pulse to the owning requester.
REQ-010 rdata  output  8  registered read data, valid in the done cycle, held until next read completes.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 cmd_memory  output  8  memory command: 0x00 idle, 0x01 read, 0x02 write.
REQ-013 addr_memory  output  8  memory address.
REQ-014 data_memory  inout  8  bidirectional memory data bus.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, WAIT, DONE.
REQ-016 IDLE: if any req bit high, SHALL select a winner, latch its we/addr/wdata, set gnt, go ISSUE; else stay IDLE.
REQ-017 Arbitration SHALL be round-robin: single request wins outright; both high -> requester not granted last wins; pointer updates on each grant.
REQ-018 ISSUE (exactly one cycle): cmd_memory = 0x02 for write / 0x01 for read, addr_memory = latched address; write -> DONE, read -> WAIT.
REQ-019 WAIT: lasts RD_LAT cycles, cmd_memory = 0x00, addr_memory held; data_memory SHALL be sampled into rdata on the last WAIT cycle; then DONE.
REQ-020 DONE (one cycle): done[owner] = 1, gnt held, cmd_memory = 0x00; then IDLE with gnt cleared.
REQ-021 data_memory SHALL be driven with latched wdata only during ISSUE of a write; high-impedance in all other cycles.
REQ-022 Latency: req sampled in IDLE cycle T -> write done at T+2; read done at T+2+RD_LAT; back in IDLE at done+1.
REQ-023 Requester SHALL hold req/we/addr/wdata stable until done and drop req the cycle after done; arbiter ignores input changes after latching.
REQ-024 Requests arriving outside IDLE SHALL wait; no request is lost while held high.
REQ-025 cmd_memory SHALL never be non-zero for more than one consecutive cycle per transaction.
REQ-026 done and gnt SHALL be one-hot or zero at all times.

Reset
REQ-027 rst high at a clock edge SHALL force: state IDLE, cmd_memory 0x00, addr_memory 0x00, data_memory Z, gnt 0, done 0, busy 0, rdata 0x00, round-robin pointer favouring requester 0.
REQ-028 Reset mid-transaction SHALL abort it without issuing done; the aborted requester re-requests.

Structure
REQ-029 Command codes (CMD_IDLE/READ/WRITE) and FSM state encoding SHALL reside in a shared package used by the control unit and memory interface.
REQ-030 Round-robin selection SHALL be one sub-module, rr_arb2 (inputs req, last pointer; output one-hot winner).
REQ-031 Implementation is one FSM plus latch registers; no combinational path from req to cmd_memory.

Verification
REQ-032 Reset then req=01, we=1, addr0=0x10, wdata0=0xA5 -> cycle+1 cmd=0x02, addr=0x10, bus=0xA5; cycle+2 done=01.
REQ-033 Memory model preloaded 0x3C at 0x20, req=10, we=0, addr1=0x20, RD_LAT=1 -> cmd=0x01 one cycle, done=10 at T+3, rdata=0x3C; bus Z from arbiter throughout.
REQ-034 Both requesters held high continuously -> grants alternate 01,10,01,10; neither starves over 8 transactions.
REQ-035 RD_LAT=3 read of 0x7F at 0x05 -> done at T+5, rdata=0x7F, cmd=0x00 during all WAIT cycles.
REQ-036 rst asserted during WAIT -> next cycle IDLE, done never pulses, cmd 0x00, rdata 0x00, next grant goes to requester 0 if both request.
